// File: rtl/stopwatch_intr_pkg.sv
// Stopwatch interrupt controller shared definitions.
// Register offsets, AXI response code and write FSM states.
package stopwatch_intr_pkg;

  localparam logic [4:0] GIE_OFF = 5'h00;
  localparam logic [4:0] IER_OFF = 5'h04;
  localparam logic [4:0] ISR_OFF = 5'h08;
  localparam logic [4:0] IAR_OFF = 5'h0C;
  localparam logic [4:0] IPR_OFF = 5'h10;

  localparam logic [2:0] GIE_IDX = GIE_OFF[4:2];
  localparam logic [2:0] IER_IDX = IER_OFF[4:2];
  localparam logic [2:0] ISR_IDX = ISR_OFF[4:2];
  localparam logic [2:0] IAR_IDX = IAR_OFF[4:2];
  localparam logic [2:0] IPR_IDX = IPR_OFF[4:2];

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/stopwatch_intr_capture.sv
// Per-source interrupt capture: edge or level detect.
// A set on the same edge as an ack wins.
module stopwatch_intr_capture
  import stopwatch_intr_pkg::*;
#(
  parameter int NUM_INTR    = 1,
  parameter bit SENSITIVITY = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INTR-1:0] intr_in,
  input  logic [NUM_INTR-1:0] ack,
  output logic [NUM_INTR-1:0] isr
);

  logic [NUM_INTR-1:0] prev_q, prev_d;
  logic [NUM_INTR-1:0] isr_q, isr_d;
  logic [NUM_INTR-1:0] set;

  // detect events and merge with acks
  always_comb begin
    set    = SENSITIVITY ? (intr_in & ~prev_q)
                         : intr_in;
    prev_d = intr_in;
    isr_d  = (isr_q & ~ack) | set;
  end

  // history and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      isr_q  <= '0;
    end else begin
      prev_q <= prev_d;
      isr_q  <= isr_d;
    end
  end

  assign isr = isr_q;

endmodule

// File: rtl/stopwatch_intr_axil_slave.sv
// AXI4-Lite interrupt controller for the stopwatch IP.
// GIE/IER/ISR/IAR/IPR registers and a registered irq.
module stopwatch_intr_axil_slave
  import stopwatch_intr_pkg::*;
#(
  parameter int NUM_INTR         = 1,
  parameter bit SENSITIVITY      = 1'b1,
  parameter bit IRQ_ACTIVE_STATE = 1'b1,
  parameter int ADDR_W           = 5
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [NUM_INTR-1:0] intr_in,
  output logic                irq,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [2:0]          S_AXI_ARPROT,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  wr_state_e state_q, state_d;

  logic                out_en_q;
  logic [2:0]          awidx_q, awidx_d;
  logic [7:0]          wbyte_q, wbyte_d;
  logic                wstb_q, wstb_d;
  logic                gie_q, gie_d;
  logic [NUM_INTR-1:0] ier_q, ier_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic                aw_hs, w_hs, ar_hs;
  logic                wr_fire, wr_stb;
  logic [2:0]          wr_idx, ar_idx;
  logic [7:0]          wr_byte;
  logic [NUM_INTR-1:0] ack, isr;
  logic [31:0]         rd_word;
  logic                unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR, S_AXI_ARADDR,
                         S_AXI_WDATA, S_AXI_WSTRB,
                         wr_byte};

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_idx = S_AXI_ARADDR[4:2];

  stopwatch_intr_capture #(
    .NUM_INTR    (NUM_INTR),
    .SENSITIVITY (SENSITIVITY)
  ) u_capture (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .intr_in (intr_in),
    .ack     (ack),
    .isr     (isr)
  );

  // write FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= W_IDLE;
    else          state_q <= state_d;
  end

  // write FSM next state, channel latches, commit strobe
  always_comb begin
    state_d = state_q;
    awidx_d = awidx_q;
    wbyte_d = wbyte_q;
    wstb_d  = wstb_q;
    wr_fire = 1'b0;
    wr_idx  = awidx_q;
    wr_byte = wbyte_q;
    wr_stb  = wstb_q;
    unique case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = W_RESP;
          wr_fire = 1'b1;
          wr_idx  = S_AXI_AWADDR[4:2];
          wr_byte = S_AXI_WDATA[7:0];
          wr_stb  = S_AXI_WSTRB[0];
        end else if (aw_hs) begin
          state_d = W_HAVE_AW;
          awidx_d = S_AXI_AWADDR[4:2];
        end else if (w_hs) begin
          state_d = W_HAVE_W;
          wbyte_d = S_AXI_WDATA[7:0];
          wstb_d  = S_AXI_WSTRB[0];
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          state_d = W_RESP;
          wr_fire = 1'b1;
          wr_byte = S_AXI_WDATA[7:0];
          wr_stb  = S_AXI_WSTRB[0];
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          state_d = W_RESP;
          wr_fire = 1'b1;
          wr_idx  = S_AXI_AWADDR[4:2];
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) state_d = W_IDLE;
      end
    endcase
  end

  // write channel outputs from state
  always_comb begin
    S_AXI_AWREADY = out_en_q &&
                    (state_q == W_IDLE ||
                     state_q == W_HAVE_W);
    S_AXI_WREADY  = out_en_q &&
                    (state_q == W_IDLE ||
                     state_q == W_HAVE_AW);
    S_AXI_BVALID  = (state_q == W_RESP);
    S_AXI_BRESP   = AXI_RESP_OKAY;
  end

  // register updates from a committed write
  always_comb begin
    gie_d = gie_q;
    ier_d = ier_q;
    ack   = '0;
    if (wr_fire && wr_stb) begin
      unique case (1'b1)
        (wr_idx == GIE_IDX): gie_d = wr_byte[0];
        (wr_idx == IER_IDX): ier_d = wr_byte[NUM_INTR-1:0];
        (wr_idx == IAR_IDX): ack   = wr_byte[NUM_INTR-1:0];
        default: ;
      endcase
    end
  end

  // read mux, read response and irq next values
  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      (ar_idx == GIE_IDX): rd_word[0] = gie_q;
      (ar_idx == IER_IDX): rd_word[NUM_INTR-1:0] = ier_q;
      (ar_idx == ISR_IDX): rd_word[NUM_INTR-1:0] = isr;
      (ar_idx == IPR_IDX): rd_word[NUM_INTR-1:0] = isr & ier_q;
      default: ;
    endcase
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    irq_d = gie_q && |(isr & ier_q);
  end

  // datapath registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_en_q <= 1'b0;
      awidx_q  <= '0;
      wbyte_q  <= '0;
      wstb_q   <= 1'b0;
      gie_q    <= 1'b0;
      ier_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_en_q <= 1'b1;
      awidx_q  <= awidx_d;
      wbyte_q  <= wbyte_d;
      wstb_q   <= wstb_d;
      gie_q    <= gie_d;
      ier_q    <= ier_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign S_AXI_ARREADY = out_en_q && !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign irq = irq_q ? IRQ_ACTIVE_STATE
                     : !IRQ_ACTIVE_STATE;

endmodule

// File: doc/stopwatch_intr_axil_slave.md
Name: stopwatch_intr_axil_slave

Overview:
- AXI4-Lite responder implementing the stopwatch IP's interrupt controller (S_AXI_INTR register space).
- Latches interrupt events from the stopwatch core (lap/alarm/overflow sources) and drives the level irq output toward the PS/interrupt fabric.
- Sits behind the block-design AXI interconnect at base 0x44A00000.
- Register map: GIE 0x00, IER 0x04, ISR 0x08, IAR 0x0C, IPR 0x10.

Parameters:
- NUM_INTR, 1, number of interrupt sources; legal range 1..8.
- SENSITIVITY, 1'b1, 1 = rising-edge event capture, 0 = level capture.
- IRQ_ACTIVE_STATE, 1'b1, asserted polarity of irq.
- ADDR_W, 5, AXI address width; byte addressing, word aligned.

Ports:
- ACLK  in  1  single clock for the whole block.
- ARESETN  in  1  asynchronous, active-low reset.
- intr_in  in  NUM_INTR  event sources from the stopwatch core, synchronous to ACLK.
- irq  out  1  interrupt output, polarity IRQ_ACTIVE_STATE.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.

Behaviour:
- Reset (async assert, sync release): all registers 0. AWREADY=WREADY=ARREADY=0 during reset, 1 the first cycle after release. BVALID=RVALID=0, RDATA=0, BRESP=RRESP=00, irq = !IRQ_ACTIVE_STATE, edge-detect history = 0.
- Write path: AW and W are accepted independently.
  - AWREADY is high while no address is latched and BVALID=0; WREADY likewise for data.
  - Once both are latched, the register update happens on that edge and BVALID rises the next cycle with BRESP=OKAY.
  - BVALID holds until BREADY; both READYs stay low until the B handshake completes.
  - Simultaneous AW+W in idle gives BVALID 1 cycle after the handshake edge.
- Read path: ARREADY is high when RVALID=0.
  - On the AR handshake, RDATA and RVALID=1 are registered on the next edge.
  - RDATA/RVALID hold until RREADY; ARREADY stays low while RVALID=1.
  - Reads and writes proceed concurrently.
- Address decode uses ADDR[4:2]; ADDR[1:0] and PROT are ignored.
  - Unmapped offsets: reads return 0 with OKAY; writes are dropped with OKAY.
  - Writes affect byte 0 only, and only if WSTRB[0]=1.
- Registers:
  - GIE[0]: R/W.
  - IER[NUM_INTR-1:0]: R/W.
  - ISR: read-only status.
  - IAR: write-1-to-clear into ISR; reads as 0.
  - IPR = ISR & IER: read-only.
  - Unused bits read 0.
- Capture:
  - Edge mode: ISR[i] sets on the edge where intr_in[i]=1 and the previous sample was 0.
  - Level mode: ISR[i] sets on any edge where intr_in[i]=1.
  - Capture is independent of IER and GIE.
- Set/ack collision: if the same bit is set and acked on the same edge, set wins and ISR stays 1. In level mode, a held source re-sets the bit immediately after an ack.
- irq is registered: irq = GIE & |(ISR & IER), with one-cycle lag from the ISR/IER/GIE update. Event at edge k gives irq asserted after edge k+1.
- Disabling IER or GIE deasserts irq one cycle later; ISR is retained.
- Reset mid-transaction aborts it; no BVALID/RVALID after release for a transaction started before reset.

Decomposition:
- Shared package stopwatch_intr_pkg holds:
  - register offset constants GIE_OFF=5'h00, IER_OFF=5'h04, ISR_OFF=5'h08, IAR_OFF=5'h0C, IPR_OFF=5'h10;
  - AXI_RESP_OKAY=2'b00;
  - typedef of write-FSM states W_IDLE/W_HAVE_AW/W_HAVE_W/W_RESP.
- One sub-module, stopwatch_intr_capture: edge/level detect plus ISR set/clear per source, parameterised by NUM_INTR and SENSITIVITY.

Test Plan:
- Basic interrupt flow:
  - Stimulus: after reset, write GIE=1, IER=1, pulse intr_in[0] for 1 cycle.
  - Required: irq goes active 2 edges after the pulse; IPR reads 0x1; write IAR=1; IPR reads 0x0; irq inactive.
- Masking:
  - Stimulus: IER=0, pulse intr_in[0].
  - Required: ISR=0x1, IPR=0x0, irq inactive.
  - Then write IER=1: irq asserts 1 cycle after the write handshake.
- Independent channels:
  - Stimulus: W presented 3 cycles before AW; BREADY held low for 4 cycles.
  - Required: BVALID held with BRESP=00; no second AWREADY until the B handshake; register updated once.
- Collision:
  - Stimulus: IAR write of 0x1 landing on the same edge as a new intr_in[0] rising edge.
  - Required: ISR[0] remains 1.
  - Also: level mode with source held high gives ISR re-set after ack.
- Unmapped/strobe:
  - Stimulus: read 0x14; write IER=0xFF with WSTRB=4'b0000.
  - Required: read returns 0 with OKAY; IER unchanged.
- Reset mid-read:
  - Stimulus: ARVALID accepted, RREADY low, ARESETN pulsed low.
  - Required: RVALID=0 immediately; irq inactive; all registers read 0 afterwards.
